// File: rtl/mem_responder.sv
// Unified instruction/data memory responder for the multi-cycle MIPS core:
// one request at a time, WAIT_CYCLES wait states, single-cycle ack. Define MEM_RESP_ERR_EN for access-error reporting.
module mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        err
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT  = 4'(WAIT_CYCLES);
  localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t        state_r, state_next;
  logic [3:0]    cnt_r, cnt_next;
  logic          capture_s, commit_s;
  logic          we_r;
  logic [31:0]   addr_r, wdata_r;
  logic          txn_we_s;
  logic [31:0]   txn_addr_s, txn_wdata_s;
  logic [AW-1:0] idx_s;
  logic          commit_err_s;
  logic [31:0]   rdata_r;
  logic          ack_r, busy_r, err_r;
  logic [31:0]   mem [DEPTH_WORDS];

`ifdef MEM_RESP_ERR_EN
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;

  function automatic logic access_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({1'b0, a} >= LIMIT);
  endfunction

  assign commit_err_s = access_err(txn_addr_s);
`else
  logic unused_addr_bits_s;
  assign unused_addr_bits_s = ^{txn_addr_s[31:AW+2], txn_addr_s[1:0]};
  assign commit_err_s       = 1'b0;
`endif

  // With zero wait states the commit edge is the accept edge, so commit uses the live inputs in IDLE.
  always_comb begin
    txn_we_s    = we_r;
    txn_addr_s  = addr_r;
    txn_wdata_s = wdata_r;
    if (state_r == ST_IDLE) begin
      txn_we_s    = we;
      txn_addr_s  = addr;
      txn_wdata_s = wdata;
    end else begin
      txn_we_s    = we_r;
      txn_addr_s  = addr_r;
      txn_wdata_s = wdata_r;
    end
  end

  assign idx_s = txn_addr_s[AW+1:2];

  // Next-state, wait counter, capture and commit decode.
  always_comb begin
    state_next = state_r;
    cnt_next   = cnt_r;
    capture_s  = 1'b0;
    commit_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req) begin
          capture_s = 1'b1;
          if (ZERO_WAIT) begin
            state_next = ST_RESP;
            commit_s   = 1'b1;
          end else begin
            state_next = ST_WAIT;
            cnt_next   = CNT_INIT;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd1) begin
          state_next = ST_RESP;
          commit_s   = 1'b1;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt_r - 4'd1;
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // State, capture registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      we_r    <= 1'b0;
      addr_r  <= 32'h0000_0000;
      wdata_r <= 32'h0000_0000;
      rdata_r <= 32'h0000_0000;
      ack_r   <= 1'b0;
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_next;
      cnt_r   <= cnt_next;
      ack_r   <= (state_next == ST_RESP);
      busy_r  <= (state_next != ST_IDLE);
      if (capture_s) begin
        we_r    <= we;
        addr_r  <= addr;
        wdata_r <= wdata;
      end
      if (commit_s) begin
        err_r <= commit_err_s;
        if (!txn_we_s) begin
          rdata_r <= commit_err_s ? 32'h0000_0000 : mem[idx_s];
        end
      end else if (state_next == ST_IDLE) begin
        err_r <= 1'b0;
      end
    end
  end

  // Memory array is not reset; a reset on the commit edge drops the write.
  always_ff @(posedge clk) begin
    if (!reset && commit_s && txn_we_s && !commit_err_s) begin
      mem[idx_s] <= txn_wdata_s;
    end
  end

  assign rdata = rdata_r;
  assign ack   = ack_r;
  assign busy  = busy_r;
  assign err   = err_r;

endmodule

// File: tb/tb_mem_responder.sv
// Directed table-driven bench for mem_responder (WAIT_CYCLES=2 and WAIT_CYCLES=0 instances).
module tb_mem_responder;

`ifdef MEM_RESP_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we, req0, we0;
  logic [31:0] addr, wdata, addr0, wdata0;
  logic [31:0] rdata, rdata0;
  logic        ack, busy, err, ack0, busy0, err0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .busy(busy), .err(err)
  );

  mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ack(ack0), .busy(busy0), .err(err0)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One transaction; called right after a sample point while the DUT is idle.
  task automatic txn(input bit sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                     output int lat, output int bcnt, output logic [31:0] rd, output logic er);
    logic seen;
    logic cur_ack, cur_busy;
    if (sel) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    else begin req = 1'b1; we = w; addr = a; wdata = d; end
    @(posedge clk); #1;
    req = 1'b0; req0 = 1'b0;
    lat = 0; bcnt = 0; rd = 32'hxxxx_xxxx; er = 1'bx; seen = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      cur_ack  = sel ? ack0 : ack;
      cur_busy = sel ? busy0 : busy;
      if (cur_busy) bcnt++;
      if (cur_ack && !seen) begin
        lat  = i;
        rd   = sel ? rdata0 : rdata;
        er   = sel ? err0 : err;
        seen = 1'b1;
      end
      if (seen && !cur_busy) break;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int lat, bcnt, acks, ack_pos[2];
    logic [31:0] rd, rd_second;
    logic er;

    vecs[0]  = '{1'b1, 32'h0000_000C, 32'h1234_5678, 32'h1111_1111, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_000C, 32'h0,         32'h1234_5678, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0000, 32'h0000_0001, 32'h1234_5678, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0100, 32'hA5A5_A5A5, 32'h1234_5678, ERR_EN};
    vecs[4]  = '{1'b0, 32'h0000_0000, 32'h0, ERR_EN ? 32'h0000_0001 : 32'hA5A5_A5A5, 1'b0};
    vecs[5]  = '{1'b0, 32'h0000_0100, 32'h0, ERR_EN ? 32'h0000_0000 : 32'hA5A5_A5A5, ERR_EN};
    vecs[6]  = '{1'b1, 32'h0000_0002, 32'hDEAD_BEEF, ERR_EN ? 32'h0000_0000 : 32'hA5A5_A5A5, ERR_EN};
    vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0, ERR_EN ? 32'h0000_0001 : 32'hDEAD_BEEF, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_0004, 32'h55AA_55AA, ERR_EN ? 32'h0000_0001 : 32'hDEAD_BEEF, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000_0004, 32'h0, 32'h55AA_55AA, 1'b0};
    vecs[10] = '{1'b0, 32'h0000_0007, 32'h0, ERR_EN ? 32'h0000_0000 : 32'h55AA_55AA, ERR_EN};

    reset = 1'b1; req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0;
    req0 = 1'b0; we0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ack", {31'd0, ack}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    chk("reset_rdata", rdata, 32'h0);
    reset = 1'b0;

    // Known prior contents at 0x10, then a store aborted by reset mid-WAIT.
    txn(1'b0, 1'b1, 32'h10, 32'h1111_1111, lat, bcnt, rd, er);
    req = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    req = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midwait_ack", {31'd0, ack}, 32'd0);
    chk("midwait_busy", {31'd0, busy}, 32'd0);
    chk("midwait_err", {31'd0, err}, 32'd0);
    txn(1'b0, 1'b0, 32'h10, 32'h0, lat, bcnt, rd, er);
    chk("midwait_rdata", rd, 32'h1111_1111);

    for (int i = 0; i < 11; i++) begin
      txn(1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, bcnt, rd, er);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd3);
      chk($sformatf("vec%0d_busy", i), 32'(bcnt), 32'd3);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
    end

    // req held for 8 edges with inputs changing every cycle: two transactions.
    acks = 0; ack_pos[0] = 0; ack_pos[1] = 0; rd_second = 32'h0;
    for (int k = 1; k <= 14; k++) begin
      req = (k <= 8);
      if (k == 1) begin we = 1'b1; addr = 32'h20; wdata = 32'h7777_7777; end
      else if (k == 5) begin we = 1'b0; addr = 32'h20; wdata = 32'h0000_0BAD; end
      else if (k < 5) begin we = 1'b0; addr = 32'h0C + 32'(k); wdata = 32'h1000_0000 + 32'(k); end
      else begin we = 1'b1; addr = 32'h0C; wdata = 32'h2000_0000 + 32'(k); end
      @(posedge clk); #1;
      if (ack) begin
        if (acks < 2) ack_pos[acks] = k;
        if (acks == 1) rd_second = rdata;
        acks++;
      end
    end
    req = 1'b0;
    chk("stable_ack_count", 32'(acks), 32'd2);
    chk("stable_ack1_pos", 32'(ack_pos[0]), 32'd3);
    chk("stable_ack2_pos", 32'(ack_pos[1]), 32'd7);
    chk("stable_rdata", rd_second, 32'h7777_7777);
    txn(1'b0, 1'b0, 32'h0C, 32'h0, lat, bcnt, rd, er);
    chk("stable_mem_0c", rd, 32'h1234_5678);

    // Zero wait-state instance.
    txn(1'b1, 1'b1, 32'h0C, 32'hFEED_C0DE, lat, bcnt, rd, er);
    chk("zw_store_lat", 32'(lat), 32'd1);
    chk("zw_store_busy", 32'(bcnt), 32'd1);
    txn(1'b1, 1'b0, 32'h0C, 32'h0, lat, bcnt, rd, er);
    chk("zw_load_lat", 32'(lat), 32'd1);
    chk("zw_load_busy", 32'(bcnt), 32'd1);
    chk("zw_load_rdata", rd, 32'hFEED_C0DE);
    chk("zw_load_err", {31'd0, er}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
